// File: rtl/asap_pkg.sv
// Shared control-word layout and opcode map for the microcoded sequencer.
// Pure constants and types; no timing or flow control.
package asap_pkg;

   localparam int CONTROL_SIGNALS = 16;
   typedef logic [CONTROL_SIGNALS-1:0] ctrl_t;

   // Bit order, MSB first: AI AO BI BO MAI OUI II ALO ALS PCI PCO PCS MI MO FI HLT
   localparam int AI_B  = 15;
   localparam int AO_B  = 14;
   localparam int BI_B  = 13;
   localparam int BO_B  = 12;
   localparam int MAI_B = 11;
   localparam int OUI_B = 10;
   localparam int II_B  = 9;
   localparam int ALO_B = 8;
   localparam int ALS_B = 7;
   localparam int PCI_B = 6;
   localparam int PCO_B = 5;
   localparam int PCS_B = 4;
   localparam int MI_B  = 3;
   localparam int MO_B  = 2;
   localparam int FI_B  = 1;
   localparam int HLT_B = 0;

   localparam ctrl_t C_AI  = ctrl_t'(1) << AI_B;
   localparam ctrl_t C_AO  = ctrl_t'(1) << AO_B;
   localparam ctrl_t C_BI  = ctrl_t'(1) << BI_B;
   localparam ctrl_t C_BO  = ctrl_t'(1) << BO_B;
   localparam ctrl_t C_MAI = ctrl_t'(1) << MAI_B;
   localparam ctrl_t C_OUI = ctrl_t'(1) << OUI_B;
   localparam ctrl_t C_II  = ctrl_t'(1) << II_B;
   localparam ctrl_t C_ALO = ctrl_t'(1) << ALO_B;
   localparam ctrl_t C_ALS = ctrl_t'(1) << ALS_B;
   localparam ctrl_t C_PCI = ctrl_t'(1) << PCI_B;
   localparam ctrl_t C_PCO = ctrl_t'(1) << PCO_B;
   localparam ctrl_t C_PCS = ctrl_t'(1) << PCS_B;
   localparam ctrl_t C_MI  = ctrl_t'(1) << MI_B;
   localparam ctrl_t C_MO  = ctrl_t'(1) << MO_B;
   localparam ctrl_t C_FI  = ctrl_t'(1) << FI_B;
   localparam ctrl_t C_HLT = ctrl_t'(1) << HLT_B;

   typedef enum logic [3:0] {
      OP_NOP = 4'h0,
      OP_LDA = 4'h1,
      OP_ADD = 4'h2,
      OP_SUB = 4'h3,
      OP_STA = 4'h4,
      OP_LDI = 4'h5,
      OP_JMP = 4'h6,
      OP_JC  = 4'h7,
      OP_JZ  = 4'h8,
      OP_OUT = 4'hE,
      OP_HLT = 4'hF
   } opcode_e;

endpackage

// File: rtl/control_sequencer_if.sv
// Instruction/flag inputs and control/step/halted outputs of the sequencer.
// Plain wires; no handshake, outputs valid combinationally within each step.
interface control_sequencer_if #(
   parameter int WIDTH     = 8,
   parameter int MAX_STEPS = 6
);
   import asap_pkg::*;

   localparam int STEP_W = $clog2(MAX_STEPS);

   logic [WIDTH-1:0]  ireg;
   logic              zf;
   logic              cf;
   ctrl_t             ctrl;
   logic [STEP_W-1:0] step;
   logic              halted;

   modport master (output ireg, zf, cf, input ctrl, step, halted);
   modport slave  (input ireg, zf, cf, output ctrl, step, halted);

endinterface

// File: rtl/microcode_rom.sv
// Combinational microcode: (opcode, step, latched flags) -> control word + last-step marker.
// Zero latency; no backpressure.
module microcode_rom
   import asap_pkg::*;
#(
   parameter int STEP_W = 3
) (
   input  opcode_e           opcode_i,
   input  logic [STEP_W-1:0] step_i,
   input  logic              cf_l_i,
   input  logic              zf_l_i,
   output ctrl_t             ctrl_o,
   output logic              last_step_o
);

   localparam logic [STEP_W-1:0] T0 = STEP_W'(0);
   localparam logic [STEP_W-1:0] T1 = STEP_W'(1);
   localparam logic [STEP_W-1:0] T2 = STEP_W'(2);
   localparam logic [STEP_W-1:0] T3 = STEP_W'(3);
   localparam logic [STEP_W-1:0] T4 = STEP_W'(4);
   localparam logic [STEP_W-1:0] T5 = STEP_W'(5);

   always_comb begin
      ctrl_o      = '0;
      last_step_o = 1'b0;
      case (step_i)
         T0: ctrl_o = C_PCO | C_MAI;
         T1: begin
            ctrl_o = C_MO | C_II | C_PCS;
            // NOP and every undefined opcode finish right after fetch
            last_step_o = !(opcode_i inside {OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI,
                                             OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT});
         end
         T2: begin
            case (opcode_i)
               OP_LDA, OP_ADD, OP_SUB, OP_STA,
               OP_LDI, OP_JMP, OP_JC, OP_JZ: ctrl_o = C_PCO | C_MAI;
               OP_OUT: begin ctrl_o = C_AO | C_OUI; last_step_o = 1'b1; end
               OP_HLT: begin ctrl_o = C_HLT;        last_step_o = 1'b1; end
               default: ;
            endcase
         end
         T3: begin
            case (opcode_i)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: ctrl_o = C_MO | C_MAI | C_PCS;
               OP_LDI: begin ctrl_o = C_MO | C_AI | C_PCS; last_step_o = 1'b1; end
               OP_JMP: begin ctrl_o = C_MO | C_PCI;        last_step_o = 1'b1; end
               OP_JC: begin
                  ctrl_o      = cf_l_i ? (C_MO | C_PCI) : C_PCS;
                  last_step_o = 1'b1;
               end
               OP_JZ: begin
                  ctrl_o      = zf_l_i ? (C_MO | C_PCI) : C_PCS;
                  last_step_o = 1'b1;
               end
               default: ;
            endcase
         end
         T4: begin
            case (opcode_i)
               OP_LDA: begin ctrl_o = C_MO | C_AI; last_step_o = 1'b1; end
               OP_ADD, OP_SUB: ctrl_o = C_MO | C_BI;
               OP_STA: begin ctrl_o = C_AO | C_MI; last_step_o = 1'b1; end
               default: ;
            endcase
         end
         T5: begin
            case (opcode_i)
               OP_ADD: begin ctrl_o = C_ALO | C_AI | C_FI;         last_step_o = 1'b1; end
               OP_SUB: begin ctrl_o = C_ALO | C_AI | C_FI | C_ALS; last_step_o = 1'b1; end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Microstep sequencer: step counter, latched ALU flags and halt state around the microcode ROM.
// Control word is zero-latency within a step; no backpressure, halts permanently on HLT until reset.
module control_sequencer
   import asap_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int OPCODE_BITS = 4,
   parameter int MAX_STEPS   = 6,
   parameter int EARLY_END   = 1
) (
   input logic                clk,
   input logic                rst,
   control_sequencer_if.slave bus
);

   localparam int STEP_W = $clog2(MAX_STEPS);

   if (MAX_STEPS < 6) begin : g_bad_max_steps
      $error("control_sequencer: MAX_STEPS must be >= 6");
   end

   typedef enum logic {S_RUN, S_HALT} state_e;

   state_e            state_q, state_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic              cf_l_q, cf_l_d;
   logic              zf_l_q, zf_l_d;

   opcode_e opcode;
   ctrl_t   rom_ctrl;
   ctrl_t   ctrl;
   logic    last_step;
   logic    unused_ireg;

   assign opcode      = opcode_e'(4'(bus.ireg[WIDTH-1 -: OPCODE_BITS]));
   assign unused_ireg = ^bus.ireg;

   microcode_rom #(.STEP_W(STEP_W)) u_rom (
      .opcode_i    (opcode),
      .step_i      (step_q),
      .cf_l_i      (cf_l_q),
      .zf_l_i      (zf_l_q),
      .ctrl_o      (rom_ctrl),
      .last_step_o (last_step)
   );

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      cf_l_d  = cf_l_q;
      zf_l_d  = zf_l_q;
      ctrl    = (state_q == S_HALT) ? '0 : rom_ctrl;
      if (state_q == S_RUN) begin
         // HLT freezes the step where it executed
         if (rom_ctrl[HLT_B]) begin
            state_d = S_HALT;
         end else if ((EARLY_END != 0 && last_step) || step_q == STEP_W'(MAX_STEPS - 1)) begin
            step_d = '0;
         end else begin
            step_d = step_q + 1'b1;
         end
         if (ctrl[FI_B]) begin
            cf_l_d = bus.cf;
            zf_l_d = bus.zf;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_RUN;
         step_q  <= '0;
         cf_l_q  <= 1'b0;
         zf_l_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         cf_l_q  <= cf_l_d;
         zf_l_q  <= zf_l_d;
      end
   end

   assign bus.ctrl   = ctrl;
   assign bus.step   = step_q;
   assign bus.halted = (state_q == S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: one early-end DUT (6 steps) and one full-length DUT (8 steps).
module tb_control_sequencer;

   localparam logic [15:0] AI  = 16'h8000;
   localparam logic [15:0] AO  = 16'h4000;
   localparam logic [15:0] BI  = 16'h2000;
   localparam logic [15:0] MAI = 16'h0800;
   localparam logic [15:0] OUI = 16'h0400;
   localparam logic [15:0] II  = 16'h0200;
   localparam logic [15:0] ALO = 16'h0100;
   localparam logic [15:0] ALS = 16'h0080;
   localparam logic [15:0] PCI = 16'h0040;
   localparam logic [15:0] PCO = 16'h0020;
   localparam logic [15:0] PCS = 16'h0010;
   localparam logic [15:0] MI  = 16'h0008;
   localparam logic [15:0] MO  = 16'h0004;
   localparam logic [15:0] FI  = 16'h0002;
   localparam logic [15:0] HLT = 16'h0001;
   localparam logic [15:0] FETCH0 = PCO | MAI;
   localparam logic [15:0] FETCH1 = MO | II | PCS;

   logic clk = 1'b0;
   logic rst0;
   logic rst1;

   always #5 clk = ~clk;

   control_sequencer_if #(.WIDTH(8), .MAX_STEPS(6)) bus0 ();
   control_sequencer_if #(.WIDTH(8), .MAX_STEPS(8)) bus1 ();

   control_sequencer #(.WIDTH(8), .OPCODE_BITS(4), .MAX_STEPS(6), .EARLY_END(1)) dut0 (
      .clk (clk),
      .rst (rst0),
      .bus (bus0)
   );

   control_sequencer #(.WIDTH(8), .OPCODE_BITS(4), .MAX_STEPS(8), .EARLY_END(0)) dut1 (
      .clk (clk),
      .rst (rst1),
      .bus (bus1)
   );

   typedef struct {
      int          dut;
      string       tag;
      logic [2:0]  step;
      logic [15:0] ctrl;
      logic        halted;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   passes = 0;

   // Expectation for the current cycle; the monitor compares it at the next falling edge.
   task automatic expect_cyc(input int d, input string tag, input logic [2:0] s,
                             input logic [15:0] c, input logic h);
      exp_t e;
      e.dut = d; e.tag = tag; e.step = s; e.ctrl = c; e.halted = h;
      sb_q.push_back(e);
      @(posedge clk);
      #2;
   endtask

   task automatic e0(input string tag, input logic [2:0] s, input logic [15:0] c);
      expect_cyc(0, tag, s, c, 1'b0);
   endtask

   task automatic e1(input string tag, input logic [2:0] s, input logic [15:0] c);
      expect_cyc(1, tag, s, c, 1'b0);
   endtask

   exp_t        mon_e;
   logic [2:0]  act_step;
   logic [15:0] act_ctrl;
   logic        act_halted;

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         if (mon_e.dut == 0) begin
            act_step = bus0.step; act_ctrl = bus0.ctrl; act_halted = bus0.halted;
         end else begin
            act_step = bus1.step; act_ctrl = bus1.ctrl; act_halted = bus1.halted;
         end
         checks++;
         if (act_step === mon_e.step && act_ctrl === mon_e.ctrl && act_halted === mon_e.halted)
            passes++;
         else
            $display("FAIL %s dut%0d: got step=%0d ctrl=%h halted=%b, want step=%0d ctrl=%h halted=%b",
                     mon_e.tag, mon_e.dut, act_step, act_ctrl, act_halted,
                     mon_e.step, mon_e.ctrl, mon_e.halted);
         checks++;
         if ($countones({act_ctrl[14], act_ctrl[8], act_ctrl[5], act_ctrl[2]}) <= 1)
            passes++;
         else
            $display("FAIL bus_driver_%s dut%0d: ctrl=%h drives the bus from more than one source",
                     mon_e.tag, mon_e.dut, act_ctrl);
      end
   end

   task automatic run_add(input logic [7:0] op, input logic c5, input logic z5,
                          input logic [15:0] t5);
      bus0.ireg = op;
      e0("ar_t0", 3'd0, FETCH0);
      e0("ar_t1", 3'd1, FETCH1);
      e0("ar_t2", 3'd2, PCO | MAI);
      e0("ar_t3", 3'd3, MO | MAI | PCS);
      e0("ar_t4", 3'd4, MO | BI);
      bus0.cf = c5; bus0.zf = z5;
      e0("ar_t5", 3'd5, t5);
      bus0.cf = 1'b0; bus0.zf = 1'b0;
   endtask

   task automatic run_jump(input logic [7:0] op, input string tag, input logic [15:0] t3);
      bus0.ireg = op;
      e0("jmp_t0", 3'd0, FETCH0);
      e0("jmp_t1", 3'd1, FETCH1);
      e0("jmp_t2", 3'd2, PCO | MAI);
      e0(tag, 3'd3, t3);
   endtask

   initial begin
      rst0 = 1'b0; rst1 = 1'b0;
      bus0.ireg = 8'h00; bus0.zf = 1'b0; bus0.cf = 1'b0;
      bus1.ireg = 8'h00; bus1.zf = 1'b0; bus1.cf = 1'b0;
      @(posedge clk);
      #2;
      rst0 = 1'b1;

      // NOP after reset: 0,1,0,1
      e0("nop_t0a", 3'd0, FETCH0);
      e0("nop_t1a", 3'd1, FETCH1);
      e0("nop_t0b", 3'd0, FETCH0);
      e0("nop_t1b", 3'd1, FETCH1);

      bus0.ireg = 8'h1F;
      e0("lda_t0", 3'd0, FETCH0);
      e0("lda_t1", 3'd1, FETCH1);
      e0("lda_t2", 3'd2, PCO | MAI);
      e0("lda_t3", 3'd3, MO | MAI | PCS);
      e0("lda_t4", 3'd4, MO | AI);

      // Flags latched only on the FI step
      run_add(8'h20, 1'b1, 1'b1, ALO | AI | FI);
      run_jump(8'h70, "jc_set", MO | PCI);
      run_jump(8'h80, "jz_set", MO | PCI);

      bus0.cf = 1'b1; bus0.zf = 1'b1;
      bus0.ireg = 8'h30;
      e0("sub_t0", 3'd0, FETCH0);
      e0("sub_t1", 3'd1, FETCH1);
      e0("sub_t2", 3'd2, PCO | MAI);
      e0("sub_t3", 3'd3, MO | MAI | PCS);
      e0("sub_t4", 3'd4, MO | BI);
      bus0.cf = 1'b0; bus0.zf = 1'b0;
      e0("sub_t5", 3'd5, ALO | AI | FI | ALS);
      bus0.cf = 1'b1; bus0.zf = 1'b1;
      run_jump(8'h70, "jc_clr", PCS);
      run_jump(8'h80, "jz_clr", PCS);
      bus0.cf = 1'b0; bus0.zf = 1'b0;

      run_add(8'h2A, 1'b1, 1'b0, ALO | AI | FI);
      run_jump(8'h70, "jc_only", MO | PCI);
      run_jump(8'h80, "jz_only", PCS);
      run_jump(8'h60, "jmp_t3", MO | PCI);

      bus0.ireg = 8'h40;
      e0("sta_t0", 3'd0, FETCH0);
      e0("sta_t1", 3'd1, FETCH1);
      e0("sta_t2", 3'd2, PCO | MAI);
      e0("sta_t3", 3'd3, MO | MAI | PCS);
      e0("sta_t4", 3'd4, AO | MI);

      bus0.ireg = 8'h55;
      e0("ldi_t0", 3'd0, FETCH0);
      e0("ldi_t1", 3'd1, FETCH1);
      e0("ldi_t2", 3'd2, PCO | MAI);
      e0("ldi_t3", 3'd3, MO | AI | PCS);

      bus0.ireg = 8'hE0;
      e0("out_t0", 3'd0, FETCH0);
      e0("out_t1", 3'd1, FETCH1);
      e0("out_t2", 3'd2, AO | OUI);

      bus0.ireg = 8'h9C;
      e0("und_t0", 3'd0, FETCH0);
      e0("und_t1", 3'd1, FETCH1);

      // Reset sampled at the edge that would enter T4 of STA
      bus0.ireg = 8'h40;
      e0("star_t0", 3'd0, FETCH0);
      e0("star_t1", 3'd1, FETCH1);
      e0("star_t2", 3'd2, PCO | MAI);
      rst0 = 1'b0;
      e0("star_t3", 3'd3, MO | MAI | PCS);
      rst0 = 1'b1;
      e0("star_rst", 3'd0, FETCH0);

      bus0.ireg = 8'hF0;
      e0("hlt_t1", 3'd1, FETCH1);
      e0("hlt_t2", 3'd2, HLT);
      for (int i = 0; i < 20; i++) expect_cyc(0, "halted", 3'd2, 16'h0000, 1'b1);
      rst0 = 1'b0;
      expect_cyc(0, "hlt_inrst", 3'd2, 16'h0000, 1'b1);
      rst0 = 1'b1;
      e0("hlt_rst0", 3'd0, FETCH0);
      e0("hlt_rst1", 3'd1, FETCH1);

      // Full-length sequencing on the 8-step DUT
      rst1 = 1'b1;
      bus1.ireg = 8'h50;
      e1("ldi8_t0", 3'd0, FETCH0);
      e1("ldi8_t1", 3'd1, FETCH1);
      e1("ldi8_t2", 3'd2, PCO | MAI);
      e1("ldi8_t3", 3'd3, MO | AI | PCS);
      for (int s = 4; s < 8; s++) e1("ldi8_idle", 3'(s), 16'h0000);
      bus1.ireg = 8'hB0;
      e1("opb_t0", 3'd0, FETCH0);
      e1("opb_t1", 3'd1, FETCH1);
      for (int s = 2; s < 8; s++) e1("opb_idle", 3'(s), 16'h0000);
      e1("opb_wrap", 3'd0, FETCH0);

      for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
      #1;
      if (sb_q.size() > 0) begin
         checks++;
         $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
